// File: rtl/pkt_merger.sv
// pkt_merger: round-robin merge of NUM_CHANNELS packet streams into one registered output.
// Define MRG_DROP_EN to drop a held packet after DROP_WAIT stalled cycles.
module pkt_merger #(
  parameter int PACKET_BITS  = 72,
  parameter int NUM_CHANNELS = 8,
  parameter int DROP_WAIT    = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PACKET_BITS-1:0] pkt_in_data_in [NUM_CHANNELS],
  input  logic                   pkt_in_vld_in  [NUM_CHANNELS],
  output logic                   pkt_in_rdy_out [NUM_CHANNELS],
  output logic [PACKET_BITS-1:0] pkt_out_data_out,
  output logic                   pkt_out_vld_out,
  input  logic                   pkt_out_rdy_in,
  output logic [1:0]             mg_cnt_out
);
  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic [PACKET_BITS-1:0] r_out_data;
  logic                   r_out_vld;
  logic [CW-1:0]          r_last_gnt;
  logic [CW-1:0]          w_gnt;
  logic [CW-1:0]          w_idx;
  logic                   w_any_vld;
  logic                   w_out_free;
  logic                   w_in_xfer;
  logic                   w_out_xfer;
  logic                   w_drop;

  assign w_out_free = !r_out_vld || pkt_out_rdy_in;

  // Walk from farthest to nearest so the channel right after last_gnt wins.
  always_comb begin
    w_gnt     = r_last_gnt;
    w_idx     = r_last_gnt;
    w_any_vld = 1'b0;
    for (int i = NUM_CHANNELS; i >= 1; i--) begin
      w_idx = r_last_gnt + CW'(i);
      if (pkt_in_vld_in[w_idx]) begin
        w_gnt     = w_idx;
        w_any_vld = 1'b1;
      end
    end
  end

  assign w_in_xfer  = reset && w_out_free && w_any_vld;
  assign w_out_xfer = reset && r_out_vld && pkt_out_rdy_in;

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++)
      pkt_in_rdy_out[c] = w_in_xfer && (w_gnt == CW'(c));
  end

`ifdef MRG_DROP_EN
  localparam int SW = $clog2(DROP_WAIT) + 1;
  logic [SW-1:0] r_stall_cnt;
  logic          w_stall;

  assign w_stall = r_out_vld && !pkt_out_rdy_in;
  // A stalled packet cannot coincide with an input transfer, so drop never races a reload.
  assign w_drop  = reset && w_stall && (r_stall_cnt == SW'(DROP_WAIT - 1));

  always_ff @(posedge clk) begin
    if (!reset)                r_stall_cnt <= '0;
    else if (!w_stall || w_drop) r_stall_cnt <= '0;
    else                       r_stall_cnt <= r_stall_cnt + 1'b1;
  end
`else
  logic w_unused_wait;
  assign w_drop        = 1'b0;
  assign w_unused_wait = (DROP_WAIT == 0);
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_last_gnt <= CW'(NUM_CHANNELS - 1);
    end else if (w_in_xfer) begin
      r_out_data <= pkt_in_data_in[w_gnt];
      r_out_vld  <= 1'b1;
      r_last_gnt <= w_gnt;
    end else if (w_out_xfer || w_drop) begin
      r_out_vld  <= 1'b0;
    end
  end

  assign pkt_out_data_out = r_out_data;
  assign pkt_out_vld_out  = r_out_vld;
  assign mg_cnt_out       = {w_out_xfer, w_drop};

endmodule

// File: tb/tb_pkt_merger.sv
// Bench for pkt_merger: per-channel source queues, round-robin order model, random backpressure.
module tb_pkt_merger;
  localparam int N  = 8;
  localparam int PB = 72;
`ifdef MRG_DROP_EN
  localparam int DW = 16;
  localparam int BP = 12;
`else
  localparam int DW = 1024;
  localparam int BP = 1100;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          out_rdy;
  logic [PB-1:0] din  [N];
  logic          vin  [N];
  logic          rout [N];
  logic [PB-1:0] dout;
  logic          vout;
  logic [1:0]    mg;

  pkt_merger #(.PACKET_BITS(PB), .NUM_CHANNELS(N), .DROP_WAIT(DW)) dut (
    .clk(clk), .reset(rst_n),
    .pkt_in_data_in(din), .pkt_in_vld_in(vin), .pkt_in_rdy_out(rout),
    .pkt_out_data_out(dout), .pkt_out_vld_out(vout), .pkt_out_rdy_in(out_rdy),
    .mg_cnt_out(mg)
  );

  always #5 clk = ~clk;

  logic [PB-1:0] q [N][$];
  logic [PB-1:0] expq [$];
  int            lg, seq, n_cmp, n_err, n_fwd, n_drop, stall_run, nc;
  bit            prev_stall, prev_drop;
  logic [PB-1:0] prev_data, s_data, pa, pb;
  logic          s_vld;
  logic [1:0]    s_cnt;
  logic [N-1:0]  s_rdy;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PB-1:0] mkpkt(input int c);
    seq++;
    return {8'(c), 16'(seq), $urandom(), 16'($urandom())};
  endfunction

  function automatic logic [N-1:0] rdy_vec();
    logic [N-1:0] v;
    for (int c = 0; c < N; c++) v[c] = rout[c];
    return v;
  endfunction

  function automatic bit all_empty();
    for (int c = 0; c < N; c++) if (q[c].size() != 0) return 0;
    return 1;
  endfunction

  task automatic drive();
    for (int c = 0; c < N; c++) begin
      vin[c] = (q[c].size() > 0);
      din[c] = (q[c].size() > 0) ? q[c][0] : '0;
    end
  endtask

  // Round-robin order of everything queued now, starting after the last grant.
  task automatic build_exp();
    int pos [N];
    bit found;
    for (int c = 0; c < N; c++) pos[c] = 0;
    do begin
      found = 0;
      for (int i = 1; i <= N; i++) begin
        int c;
        c = (lg + i) % N;
        if (pos[c] < q[c].size()) begin
          expq.push_back(q[c][pos[c]]);
          pos[c]++;
          lg    = c;
          found = 1;
          break;
        end
      end
    end while (found);
  endtask

  task automatic cycle();
    logic [N-1:0] vv;
    bit fwd, stall, edrop;
    int ic;
    @(negedge clk);
    s_rdy = rdy_vec();
    for (int c = 0; c < N; c++) vv[c] = vin[c];
    s_vld = vout; s_data = dout; s_cnt = mg;
    chk("rdy_count", $countones(s_rdy), (rst_n && (|vv) && (!s_vld || out_rdy)) ? 1 : 0);
    chk("rdy_without_vld", s_rdy & ~vv, 0);
    stall = rst_n && s_vld && !out_rdy;
`ifdef MRG_DROP_EN
    edrop = stall && (stall_run == DW - 1);
`else
    edrop = 0;
`endif
    fwd = rst_n && s_vld && out_rdy;
    chk("cnt_enables", s_cnt, {fwd, edrop});
    if (rst_n && prev_stall && !prev_drop) chk("hold_stable", {s_vld, s_data}, {1'b1, prev_data});
    if (fwd) begin
      n_fwd++;
      chk("exp_nonempty", (expq.size() > 0), 1);
      if (expq.size() > 0) chk("out_data", s_data, expq.pop_front());
    end
    if (edrop) begin
      n_drop++;
      if (expq.size() > 0) void'(expq.pop_front());
    end
    stall_run  = (stall && !edrop) ? stall_run + 1 : 0;
    prev_stall = stall;
    prev_drop  = edrop;
    prev_data  = s_data;
    ic = -1;
    for (int c = 0; c < N; c++) if (s_rdy[c] && vv[c]) ic = c;
    @(posedge clk);
    #1;
    if (ic >= 0) void'(q[ic].pop_front());
    drive();
  endtask

  task automatic run(input int mode, input int maxc, output int ncyc);
    bit done;
    ncyc = 0;
    done = 0;
    while (!done && ncyc < maxc) begin
      if (mode == 1) out_rdy = 1'b1;
      else begin
        out_rdy = 1'($urandom_range(0, 1));
`ifdef MRG_DROP_EN
        if (stall_run >= 8) out_rdy = 1'b1;
`endif
      end
      cycle();
      ncyc++;
      done = (expq.size() == 0) && all_empty();
    end
    chk("run_done", done, 1);
  endtask

  task automatic single(input int c);
    q[c].push_back(mkpkt(c));
    build_exp();
    drive();
    run(1, 20, nc);
  endtask

  initial begin
    int f0;
    n_cmp = 0; n_err = 0; n_fwd = 0; n_drop = 0; seq = 0;
    stall_run = 0; prev_stall = 0; prev_drop = 0; prev_data = '0;
    lg = N - 1;
    rst_n = 1'b0; out_rdy = 1'b0;
    drive();
    repeat (4) cycle();
    chk("rst_vld", vout, 0);
    chk("rst_data", dout, 0);
    chk("rst_cnt", mg, 0);
    chk("rst_rdy", rdy_vec(), 0);
    rst_n = 1'b1;

    // pass-through on channel 3
    pa = mkpkt(3); pa[7:0] = 8'hA5;
    q[3].push_back(pa);
    build_exp(); drive(); out_rdy = 1'b1;
    cycle();
    chk("pt_gnt", s_rdy, 8'b0000_1000);
    chk("pt_vld_before", s_vld, 0);
    cycle();
    chk("pt_vld_after", s_vld, 1);
    chk("pt_data", s_data, pa);
    chk("pt_cnt", s_cnt, 2'b10);
    cycle();
    chk("pt_vld_end", s_vld, 0);
    chk("pt_cnt_end", s_cnt, 2'b00);

    // backpressure: ch0 held, then ch5
    single(7);
    pa = mkpkt(0); pb = mkpkt(5);
    q[0].push_back(pa); q[5].push_back(pb);
    build_exp(); drive(); out_rdy = 1'b0;
    repeat (BP) cycle();
    chk("bp_vld", s_vld, 1);
    chk("bp_data", s_data, pa);
    chk("bp_rdy", s_rdy, 0);
    chk("bp_no_fwd", s_cnt, 2'b00);
    run(1, 20, nc);

    // wrap-around: last grant 7, then 0 and 6
    single(7);
    pa = mkpkt(0); pb = mkpkt(6);
    q[0].push_back(pa); q[6].push_back(pb);
    build_exp(); drive(); out_rdy = 1'b1;
    cycle();
    chk("wrap_first_gnt", s_rdy, 8'b0000_0001);
    run(1, 20, nc);

    // fairness: all channels, 4 packets each, no bubbles
    single(7);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < N; c++) q[c].push_back(mkpkt(c));
    build_exp(); drive();
    f0 = n_fwd;
    run(1, 100, nc);
    chk("fair_cycles", nc, 33);
    chk("fair_fwd", n_fwd - f0, 32);

    // random channel subsets with random backpressure
    repeat (4) begin
      for (int c = 0; c < N; c++) begin
        int k;
        k = $urandom_range(0, 5);
        for (int j = 0; j < k; j++) q[c].push_back(mkpkt(c));
      end
      build_exp(); drive();
      run(0, 3000, nc);
    end

`ifdef MRG_DROP_EN
    // stall-timeout drop
    f0 = n_drop;
    pa = mkpkt(1); pb = mkpkt(1);
    q[1].push_back(pa); q[1].push_back(pb);
    build_exp(); drive(); out_rdy = 1'b0;
    cycle();
    for (int k = 1; k <= 16; k++) begin
      cycle();
      chk("dr_vld", s_vld, 1);
    end
    chk("dr_pulse", s_cnt, 2'b01);
    cycle();
    chk("dr_gap", s_vld, 0);
    cycle();
    chk("dr_next_vld", s_vld, 1);
    chk("dr_next_data", s_data, pb);
    run(1, 20, nc);
    chk("dr_count", n_drop - f0, 1);

    // ready arrives on the last stall cycle: forwarded, not dropped
    pa = mkpkt(3); pb = mkpkt(3);
    q[3].push_back(pa); q[3].push_back(pb);
    build_exp(); drive(); out_rdy = 1'b0;
    repeat (16) cycle();
    out_rdy = 1'b1;
    cycle();
    chk("rs_cnt", s_cnt, 2'b10);
    chk("rs_data", s_data, pa);
    run(1, 20, nc);
    chk("rs_no_drop", n_drop - f0, 1);
`endif

    // reset while a packet is held
    pa = mkpkt(1);
    q[1].push_back(pa);
    build_exp(); drive(); out_rdy = 1'b0;
    cycle();
    cycle();
    chk("rm_held", s_vld, 1);
    q[0].push_back(mkpkt(0)); q[4].push_back(mkpkt(4));
    drive();
    f0 = n_fwd;
    rst_n = 1'b0;
    cycle();
    chk("rm_vld", vout, 0);
    chk("rm_data", dout, 0);
    chk("rm_cnt", mg, 0);
    chk("rm_rdy", rdy_vec(), 0);
    rst_n = 1'b1;
    expq.delete();
    lg = N - 1; stall_run = 0; prev_stall = 0; prev_drop = 0;
    build_exp(); out_rdy = 1'b1; drive();
    cycle();
    chk("rm_first_gnt", s_rdy, 8'b0000_0001);
    chk("rm_not_reappear", s_vld, 0);
    run(1, 20, nc);
    chk("rm_fwd", n_fwd - f0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pkt_merger.md
Name: pkt_merger

Overview:
- Reverse path of the outgoing packet router: merges packets arriving on NUM_CHANNELS HSSL channels into one packet stream for the peripheral side.
- Round-robin arbitration, one registered output stage, optional stall-timeout packet dropping.
- Per-packet count enables feed the existing packet counters.

Parameters:
PACKET_BITS, 72, packet width in bits (key + payload, carried unmodified)
NUM_CHANNELS, 8, number of input channels (power of 2, 2..16)
DROP_WAIT, 1024, output stall cycles before the held packet is dropped (only with MRG_DROP_EN)

Ports:
clk  input  1  clock
reset  input  1  synchronous reset, active-low
pkt_in_data_in  input  PACKET_BITS x NUM_CHANNELS (unpacked array)  per-channel packet
pkt_in_vld_in  input  1 x NUM_CHANNELS (unpacked array)  per-channel valid
pkt_in_rdy_out  output  1 x NUM_CHANNELS (unpacked array)  per-channel ready
pkt_out_data_out  output  PACKET_BITS  merged packet
pkt_out_vld_out  output  1  merged valid
pkt_out_rdy_in  input  1  merged ready
mg_cnt_out  output  2  count enables: [0] dropped, [1] forwarded

Behaviour:
- Reset: reset == 0 sampled on a rising clk edge. Outputs after reset:
  - pkt_out_vld_out = 0, pkt_out_data_out = 0, mg_cnt_out = 0.
  - Every pkt_in_rdy_out = 0 while reset is low.
  - Grant pointer last_gnt = NUM_CHANNELS-1, so channel 0 has first priority.
  - Stall counter = 0.
- Reset mid-operation: the held output packet is discarded, not counted, and not presented after reset.
- Output register and free flag:
  - Single entry: out_data, out_vld.
  - out_free = !out_vld || pkt_out_rdy_in (combinational).
- Arbitration (combinational):
  - Search channels last_gnt+1, last_gnt+2, ... modulo NUM_CHANNELS, wrapping.
  - The first channel with vld = 1 is gnt.
- Ready generation:
  - pkt_in_rdy_out[c] = out_free && any_vld && (c == gnt) && reset.
  - At most one ready is high in any cycle.
  - Ready does not depend on the channel's own vld beyond the arbitration result.
- Input transfer: pkt_in_vld_in[gnt] && pkt_in_rdy_out[gnt] at an edge. On that edge:
  - out_data <= pkt_in_data_in[gnt], out_vld <= 1, last_gnt <= gnt.
- Latency: exactly 1 cycle from input transfer to pkt_out_vld_out = 1.
  - Back-to-back throughput: 1 packet/cycle while pkt_out_rdy_in = 1.
- Output transfer: pkt_out_vld_out && pkt_out_rdy_in.
  - If there is no simultaneous input transfer, out_vld <= 0.
  - Simultaneous output and input transfer: the register is reloaded, out_vld stays 1, no bubble.
- Handshake rules:
  - While pkt_out_vld_out = 1 and pkt_out_rdy_in = 0, pkt_out_data_out is held stable.
  - The held packet is never lost, except on a drop (see Optional Feature).
- No input valid: last_gnt is unchanged and no grant is issued.
- Fairness: with all channels valid continuously, each channel is granted once every NUM_CHANNELS transfers.
- Count enables (1-cycle pulses, combinational from the handshakes):
  - mg_cnt_out[1] = pkt_out_vld_out && pkt_out_rdy_in.
  - mg_cnt_out[0] = drop event.
  - The two bits are never high together.
- Packet contents: passed through unmodified; no parity or key inspection.

Optional Feature:
Macro MRG_DROP_EN.
- Defined:
  - Stall counter increments each cycle that pkt_out_vld_out && !pkt_out_rdy_in.
  - It clears on any cycle without a stall.
  - On the edge where the counter equals DROP_WAIT-1 while still stalled:
    - out_vld <= 0 and the counter clears.
    - mg_cnt_out[0] = 1 during that cycle.
  - The next pkt_out_vld_out=1 is no earlier than the following cycle (the new packet is granted in the cycle after the drop).
  - Drop and output transfer are mutually exclusive: a ready in the drop cycle wins, and the packet is forwarded, not dropped.
- Undefined: no stall counter is generated, mg_cnt_out[0] is tied 0, and stalls last indefinitely.

Test Plan:
- Pass-through: reset low 4 cycles, then channel 3 sends 0x..A5, out_rdy=1 → out_vld=1 exactly one cycle after the input transfer, data 0x..A5; mg_cnt_out=2'b10 for 1 cycle; rdy_out[c≠3]=0 throughout.
- Fairness: all 8 channels valid with 4 packets each, out_rdy=1 → output channel order 0,1,...,7 repeated 4 times; 32 consecutive transfers with no bubble; 32 forward pulses.
- Backpressure: channels 0 and 5 valid, out_rdy=0 for 20 cycles → one packet held stable; all pkt_in_rdy_out=0 after first transfer; releasing out_rdy → ch0 packet, then ch5 packet.
- Wrap-around: last grant channel 7, channels 0 and 6 valid → channel 0 granted first, then 6.
- Reset mid-stream: assert reset while out_vld=1, out_rdy=0 → next cycle out_vld=0, data 0, rdy_out all 0; no count pulse; the packet does not reappear; first grant after reset is channel 0.
- MRG_DROP_EN, DROP_WAIT=16: out_rdy=0 held → out_vld falls after 16 stall cycles; mg_cnt_out=2'b01 for 1 cycle; next queued packet appears 1 cycle later. Same scenario with out_rdy raised at stall cycle 16 → packet forwarded, no drop pulse.
